// File: rtl/pixel_sink_if.sv
// pixel_sink_if: bundles the pixel-plot request side and the framebuffer write side of
// pixel_sink.
//   master: drawing logic / framebuffer model (drives plot, x, y, color, mem_busy)
//   slave : pixel_sink (drives ready, empty, mem_addr, mem_data, mem_wren, dropped)
interface pixel_sink_if;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        ready;
  logic        empty;
  logic        mem_busy;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  dropped;

  modport master (
    output plot, x, y, color, mem_busy,
    input  ready, empty, mem_addr, mem_data, mem_wren, dropped
  );

  modport slave (
    input  plot, x, y, color, mem_busy,
    output ready, empty, mem_addr, mem_data, mem_wren, dropped
  );
endinterface

// File: rtl/pixel_sink.sv
// pixel_sink: accepts one (x, y, color) pixel per plot strobe and clips off-screen pixels.
// It converts on-screen pixels to a linear 160x120 framebuffer address, buffers them in a
// DEPTH-entry FIFO and drains them into a stallable framebuffer write port.
// Ports:
//   clk    - system clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - pixel_sink_if.slave: plot/x/y/color/ready/empty on the request side,
//            mem_busy/mem_addr/mem_data/mem_wren on the write side, dropped counter
// Build option: define PIXEL_SINK_KEY_EN to discard pixels whose colour equals KEY_COLOR.
module pixel_sink #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [2:0]  KEY_COLOR = 3'b101
) (
  input  logic         clk,
  input  logic         resetn,
  pixel_sink_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  ptr_t        wptr_q, wptr_d;
  ptr_t        rptr_q, rptr_d;
  logic [17:0] fifo_q [DEPTH];
  logic [17:0] head;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [2:0]  mem_data_q, mem_data_d;
  logic        mem_wren_q, mem_wren_d;
  logic [7:0]  dropped_q, dropped_d;

  logic        full, empty, accept, on_screen, keyed, push, pop;
  logic [14:0] y_ext, addr;

  // Full when the pointers index the same slot but differ in the wrap bit.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign accept    = bus.plot && !full;
  assign on_screen = (bus.x < 8'd160) && (bus.y < 7'd120);

  // y*160 as two shifts; maximum 19199 fits in 15 bits.
  assign y_ext = {8'd0, bus.y};
  assign addr  = (y_ext << 7) + (y_ext << 5) + {7'd0, bus.x};

`ifdef PIXEL_SINK_KEY_EN
  assign keyed = (bus.color == KEY_COLOR);
`else
  logic unused_key_color;
  assign unused_key_color = ^KEY_COLOR;
  assign keyed = 1'b0;
`endif

  assign push = accept && on_screen && !keyed;
  assign pop  = !empty && !bus.mem_busy;
  assign head = fifo_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d     = wptr_q + ptr_t'(push);
    rptr_d     = rptr_q + ptr_t'(pop);
    mem_wren_d = pop;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (pop) begin
      mem_addr_d = head[17:3];
      mem_data_d = head[2:0];
    end
    dropped_d = dropped_q;
    if (accept && !on_screen && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
      dropped_q  <= dropped_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q[AW-1:0]] <= {addr, bus.color};
    end
  end

  assign bus.ready    = !full;
  assign bus.empty    = empty;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_wren = mem_wren_q;
  assign bus.dropped  = dropped_q;

endmodule

// File: tb/tb_pixel_sink.sv
module tb_pixel_sink;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  pixel_sink_if pif ();

  pixel_sink #(
    .DEPTH     (DEPTH),
    .KEY_COLOR (3'b101)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (pif)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model: queue of pending pixels encoded as addr*8+color.
  int mq[$];
  int m_drop = 0;
  int m_wren = 0;
  int m_addr = 0;
  int m_data = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_key(input int c);
`ifdef PIXEL_SINK_KEY_EN
    return c == 5;
`else
    return c < 0;
`endif
  endfunction

  initial begin
    forever begin : model_step
      int  sz;
      bit  acc;
      int  px, py, pc;
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        mq.delete();
        m_drop = 0;
        m_wren = 0;
        m_addr = 0;
        m_data = 0;
      end else begin
        sz  = mq.size();
        acc = pif.plot && (sz < DEPTH);
        px  = int'(pif.x);
        py  = int'(pif.y);
        pc  = int'(pif.color);
        if (sz > 0 && !pif.mem_busy) begin
          m_wren = 1;
          m_addr = mq[0] / 8;
          m_data = mq[0] % 8;
          void'(mq.pop_front());
        end else begin
          m_wren = 0;
        end
        if (acc) begin
          if (px >= 160 || py >= 120) begin
            if (m_drop < 255) m_drop++;
          end else if (!is_key(pc)) begin
            mq.push_back((py * 160 + px) * 8 + pc);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", int'(pif.ready), int'(mq.size() < DEPTH));
      chk("empty", int'(pif.empty), int'(mq.size() == 0));
      chk("mem_wren", int'(pif.mem_wren), m_wren);
      chk("mem_addr", int'(pif.mem_addr), m_addr);
      chk("mem_data", int'(pif.mem_data), m_data);
      chk("dropped", int'(pif.dropped), m_drop);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input bit p, input int px, input int py, input int pc);
    pif.plot  = p;
    pif.x     = 8'(px);
    pif.y     = 7'(py);
    pif.color = 3'(pc);
  endtask

  initial begin : main
    int wseen;
    int last_addr;
    int last_data;
    int first_cyc;
    int last_cyc;
    int exp_writes;
    pix(1'b0, 0, 0, 0);
    pif.mem_busy = 1'b0;
    #2 resetn = 1'b0;
    chk_en = 1'b1;
    step();
    step();
    chk("rst_wren", int'(pif.mem_wren), 0);
    chk("rst_addr", int'(pif.mem_addr), 0);
    chk("rst_data", int'(pif.mem_data), 0);
    chk("rst_dropped", int'(pif.dropped), 0);
    chk("rst_empty", int'(pif.empty), 1);
    chk("rst_ready", int'(pif.ready), 1);
    resetn = 1'b1;
    step();

    // Single pixel: 2-cycle latency, addr 2*160+5.
    pix(1'b1, 5, 2, 2);
    step();
    pix(1'b0, 0, 0, 0);
    @(negedge clk);
    chk("lat_wren_early", int'(pif.mem_wren), 0);
    step();
    @(negedge clk);
    chk("lat_wren", int'(pif.mem_wren), 1);
    chk("lat_addr", int'(pif.mem_addr), 325);
    chk("lat_data", int'(pif.mem_data), 2);
    step();
    @(negedge clk);
    chk("lat_single", int'(pif.mem_wren), 0);

    // Corners and clipping.
    step();
    pix(1'b1, 159, 119, 7);
    step();
    pix(1'b1, 0, 0, 1);
    step();
    chk("corner_hi", int'(pif.mem_addr), 19199);
    pix(1'b1, 160, 0, 4);
    step();
    chk("corner_lo", int'(pif.mem_addr), 0);
    pix(1'b1, 0, 120, 4);
    step();
    pix(1'b0, 0, 0, 0);
    step();
    step();
    chk("clip_dropped", int'(pif.dropped), 2);

    // Busy fill: ready falls after 8 accepted, then 8 ordered back-to-back writes.
    pif.mem_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pix(1'b1, 10 + i, 3, i % 8);
      step();
      if (i == 7) begin
        @(negedge clk);
        chk("full_ready", int'(pif.ready), 0);
        chk("full_empty", int'(pif.empty), 0);
      end
    end
    pix(1'b0, 0, 0, 0);
    pif.mem_busy = 1'b0;
    wseen = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pif.mem_wren) begin
        chk("drain_order", int'(pif.mem_addr), 480 + 10 + wseen);
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        wseen++;
      end
    end
    chk("drain_count", wseen, 8);
    chk("drain_consec", last_cyc - first_cyc, 7);
    chk("drain_empty", int'(pif.empty), 1);
    step();

    // Saturation with 300 off-screen plots.
    wseen = 0;
    for (int i = 0; i < 300; i++) begin
      pix(1'b1, 200, i % 128, 1);
      step();
      if (pif.mem_wren) wseen++;
    end
    pix(1'b0, 0, 0, 0);
    step();
    chk("sat_dropped", int'(pif.dropped), 255);
    chk("sat_nowrite", wseen, 0);

    // Reset with pixels queued and a write on the bus.
    pif.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix(1'b1, i, 4, 6);
      step();
    end
    pix(1'b0, 0, 0, 0);
    pif.mem_busy = 1'b0;
    step();
    chk("pre_rst_wren", int'(pif.mem_wren), 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_wren", int'(pif.mem_wren), 0);
    chk("arst_ready", int'(pif.ready), 1);
    chk("arst_empty", int'(pif.empty), 1);
    chk("arst_dropped", int'(pif.dropped), 0);
    step();
    step();
    resetn = 1'b1;
    wseen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pif.mem_wren) wseen++;
    end
    chk("post_rst_nowrite", wseen, 0);

    // Randomized traffic with stalls; the per-cycle compare does the checking.
    for (int i = 0; i < 2000; i++) begin
      pix($urandom_range(0, 3) != 0, $urandom_range(0, 175), $urandom_range(0, 127),
          $urandom_range(0, 7));
      pif.mem_busy = ($urandom_range(0, 9) < 4);
      step();
    end
    pix(1'b0, 0, 0, 0);
    pif.mem_busy = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) step();
    chk("rand_drained", int'(pif.empty), 1);

    // Colour key at (1,1).
    pix(1'b1, 1, 1, 5);
    step();
    pix(1'b1, 1, 1, 3);
    step();
    pix(1'b0, 0, 0, 0);
    wseen = 0;
    last_addr = -1;
    last_data = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pif.mem_wren) begin
        wseen++;
        last_addr = int'(pif.mem_addr);
        last_data = int'(pif.mem_data);
      end
      step();
    end
`ifdef PIXEL_SINK_KEY_EN
    exp_writes = 1;
`else
    exp_writes = 2;
`endif
    chk("key_writes", wseen, exp_writes);
    chk("key_addr", last_addr, 161);
    chk("key_data", last_data, 3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
